// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: iterative double-dabble (shift-and-add-3) binary-to-BCD converter.
//
// A start pulse in idle captures bin_in. The converter then takes N shift steps and a
// single finish cycle, and raises a one-cycle done pulse together with the new
// bcd_out/ovf. Values that do not fit in DIGITS decimal digits saturate to all nines
// and set ovf.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   conversion request, honoured only in idle
//   bin_in   in   [N-1:0] binary value, sampled on the accepting edge
//   busy     out  high while a conversion is in progress
//   done     out  one-cycle pulse when bcd_out/ovf update
//   ovf      out  last converted value was >= 10^DIGITS
//   bcd_out  out  [4*DIGITS-1:0] digit 0 (ones) in [3:0], digit 1 in [7:4], ...
//
// Optional feature macro: BCD_LEADING_BLANK_EN
//   When defined, the result replaces every digit above the most significant
//   nonzero digit with 4'hF (blank). Digit 0 is never blanked, and saturated
//   (overflow) results are never blanked.
module bcd_seq_conv #(
    parameter int unsigned N      = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned CNTW = $clog2(N + 1);
    // Comparison width wide enough for both the input and 10^DIGITS.
    localparam int unsigned LW   = (N > 64) ? N : 64;

    function automatic logic [LW-1:0] pow10(input int unsigned d);
        logic [LW-1:0] p;
        p = LW'(1);
        for (int unsigned i = 0; i < d; i++) begin
            p = p * LW'(10);
        end
        return p;
    endfunction

    localparam logic [LW-1:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {StIdle, StConv, StFin} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              oflow_q, oflow_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [BW-1:0]     bcd_q, bcd_d;

    logic [BW-1:0]     scratch_adj;
    logic [BW-1:0]     result;

    // Add-3 correction on every digit >= 5, applied before the shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final value presented at the finish edge.
`ifdef BCD_LEADING_BLANK_EN
    logic seen_nz;
`endif
    always_comb begin
        result = scratch_q;
`ifdef BCD_LEADING_BLANK_EN
        seen_nz = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (scratch_q[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                result[4*i +: 4] = 4'hF;
            end
        end
`endif
        if (oflow_q) begin
            result = {DIGITS{4'd9}};
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        oflow_d   = oflow_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    count_d   = CNTW'(N);
                    oflow_d   = (LW'(bin_in) >= LIMIT);
                    busy_d    = 1'b1;
                    state_d   = StConv;
                end
            end
            StConv: begin
                scratch_d = {scratch_adj[BW-2:0], shift_q[N-1]};
                shift_d   = shift_q << 1;
                // A bit leaving the top digit means the value needs more digits.
                oflow_d   = oflow_q | scratch_adj[BW-1];
                count_d   = count_q - CNTW'(1);
                if (count_q == CNTW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                bcd_d   = result;
                ovf_d   = oflow_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            oflow_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            oflow_q   <= oflow_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;
    assign bcd_out = bcd_q;

endmodule
